// File: rtl/msx_ram_arbiter_if.sv
// rtl/msx_ram_arbiter_if.sv - requester, memory-port and status signals of the MSX RAM arbiter
interface msx_ram_arbiter_if #(
    parameter int ADDR_W = 27
);
    logic              dl_req;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_ack;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_din;
    logic              cpu_rnw;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_wait_n;

    logic              sr_req;
    logic [ADDR_W-1:0] sr_addr;
    logic [7:0]        sr_din;
    logic              sr_rnw;
    logic              sr_ack;
    logic [7:0]        sr_rdata;

    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_rnw;
    logic [7:0]        mem_dout;
    logic              mem_done;

    logic              timeout_err;

    modport slave (
        input  dl_req, dl_addr, dl_data,
        input  cpu_req, cpu_addr, cpu_din, cpu_rnw,
        input  sr_req, sr_addr, sr_din, sr_rnw,
        input  mem_dout, mem_done,
        output dl_ack, cpu_ack, cpu_rdata, cpu_wait_n, sr_ack, sr_rdata,
        output mem_ce, mem_addr, mem_din, mem_rnw, timeout_err
    );

    modport master (
        output dl_req, dl_addr, dl_data,
        output cpu_req, cpu_addr, cpu_din, cpu_rnw,
        output sr_req, sr_addr, sr_din, sr_rnw,
        output mem_dout, mem_done,
        input  dl_ack, cpu_ack, cpu_rdata, cpu_wait_n, sr_ack, sr_rdata,
        input  mem_ce, mem_addr, mem_din, mem_rnw, timeout_err
    );
endinterface

// File: rtl/msx_ram_arbiter.sv
// rtl/msx_ram_arbiter.sv - one-transfer-at-a-time arbiter of the external RAM port for download, CPU and SRAM engine
module msx_ram_arbiter #(
    parameter int ADDR_W       = 27,
    parameter int STARVE_LIMIT = 64,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk21m,
    input  logic             reset,
    msx_ram_arbiter_if.slave bus
);
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_SR} owner_t;

    state_t            r_state, w_state_nxt;
    owner_t            r_owner, w_grant_own;
    logic              w_grant, w_done, w_abort;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [7:0]        w_grant_din;
    logic              w_grant_rnw;
    logic [7:0]        w_rd_val;

    logic              r_mem_ce, r_mem_rnw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_din;
    logic              r_dl_ack, r_cpu_ack, r_sr_ack;
    logic [7:0]        r_cpu_rdata, r_sr_rdata;
    logic              r_timeout_err;
    logic [SW-1:0]     r_starve;
    logic [7:0]        r_tmo;

    always_ff @(posedge clk21m) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_own = OWN_DL;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A starved SRAM engine jumps ahead of the CPU but never ahead of a download.
                if (bus.dl_req) begin
                    w_grant = 1'b1; w_grant_own = OWN_DL;
                end else if (bus.sr_req && (r_starve >= STARVE_MAX)) begin
                    w_grant = 1'b1; w_grant_own = OWN_SR;
                end else if (bus.cpu_req) begin
                    w_grant = 1'b1; w_grant_own = OWN_CPU;
                end else if (bus.sr_req) begin
                    w_grant = 1'b1; w_grant_own = OWN_SR;
                end
                if (w_grant) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.mem_done) begin
                    w_done = 1'b1; w_state_nxt = S_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_abort = 1'b1; w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_addr = bus.dl_addr;
        w_grant_din  = bus.dl_data;
        w_grant_rnw  = 1'b0;
        case (w_grant_own)
            OWN_CPU: begin
                w_grant_addr = bus.cpu_addr; w_grant_din = bus.cpu_din; w_grant_rnw = bus.cpu_rnw;
            end
            OWN_SR: begin
                w_grant_addr = bus.sr_addr; w_grant_din = bus.sr_din; w_grant_rnw = bus.sr_rnw;
            end
            default: ;
        endcase
    end

    assign w_rd_val = w_done ? bus.mem_dout : 8'hFF;

    always_ff @(posedge clk21m) begin
        if (reset) begin
            r_owner       <= OWN_DL;
            r_mem_ce      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_mem_rnw     <= 1'b1;
            r_dl_ack      <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_sr_ack      <= 1'b0;
            r_cpu_rdata   <= 8'hFF;
            r_sr_rdata    <= 8'hFF;
            r_timeout_err <= 1'b0;
            r_starve      <= '0;
            r_tmo         <= '0;
        end else begin
            r_dl_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_sr_ack  <= 1'b0;
            if (w_grant) begin
                r_owner    <= w_grant_own;
                r_mem_addr <= w_grant_addr;
                r_mem_din  <= w_grant_din;
                r_mem_rnw  <= w_grant_rnw;
                r_mem_ce   <= 1'b1;
                r_tmo      <= '0;
            end else if (r_state == S_ISSUE) begin
                r_tmo <= r_tmo + 8'd1;
            end
            // Completion and abort share one path: the ack lands in the DONE cycle either way.
            if (w_done || w_abort) begin
                r_mem_ce <= 1'b0;
                case (r_owner)
                    OWN_DL:  r_dl_ack <= 1'b1;
                    OWN_CPU: begin
                        r_cpu_ack <= 1'b1;
                        if (r_mem_rnw) r_cpu_rdata <= w_rd_val;
                    end
                    OWN_SR: begin
                        r_sr_ack <= 1'b1;
                        if (r_mem_rnw) r_sr_rdata <= w_rd_val;
                    end
                    default: ;
                endcase
            end
            if (w_abort) r_timeout_err <= 1'b1;
            if (!bus.sr_req || (w_grant && (w_grant_own == OWN_SR))) begin
                r_starve <= '0;
            end else if (!((r_state != S_IDLE) && (r_owner == OWN_SR)) && (r_starve != STARVE_MAX)) begin
                r_starve <= r_starve + STARVE_ONE;
            end
        end
    end

    assign bus.mem_ce      = r_mem_ce;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.mem_rnw     = r_mem_rnw;
    assign bus.dl_ack      = r_dl_ack;
    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.sr_ack      = r_sr_ack;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.sr_rdata    = r_sr_rdata;
    assign bus.timeout_err = r_timeout_err;
    assign bus.cpu_wait_n  = ~(bus.cpu_req & ~r_cpu_ack);
endmodule

// File: tb/tb_msx_ram_arbiter.sv
// tb/tb_msx_ram_arbiter.sv - randomized self-checking bench for msx_ram_arbiter
module tb_msx_ram_arbiter;
    localparam int AW = 27;

    logic clk21m = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         lat = 0;
    int         mcnt = 0;
    logic       r_done = 1'b0;
    logic [7:0] r_dout = 8'h3C;
    logic       stray_done = 1'b0;
    logic [7:0] phys_mem [logic [AW-1:0]];
    logic [7:0] exp_mem  [logic [AW-1:0]];

    msx_ram_arbiter_if #(.ADDR_W(AW)) bus ();

    msx_ram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(64), .TIMEOUT(255)) dut (
        .clk21m (clk21m),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk21m = ~clk21m;

    assign bus.mem_done = r_done | stray_done;
    assign bus.mem_dout = r_dout;

    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rd_phys(input logic [AW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] exp_rd(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    // Memory controller model: answers lat cycles after mem_ce rises, never if lat is huge.
    always @(posedge clk21m) begin
        #2;
        r_done = 1'b0;
        r_dout = 8'h3C;
        if (bus.mem_ce) begin
            if (mcnt == lat) begin
                r_done = 1'b1;
                if (bus.mem_rnw) r_dout = rd_phys(bus.mem_addr);
                else             phys_mem[bus.mem_addr] = bus.mem_din;
            end
            mcnt++;
        end else begin
            mcnt = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk21m);
        #1;
    endtask

    function automatic logic ack_of(input int who);
        case (who)
            0:       return bus.dl_ack;
            1:       return bus.cpu_ack;
            default: return bus.sr_ack;
        endcase
    endfunction

    task automatic drive_req(input int who, input logic v, input logic [AW-1:0] a,
                             input logic [7:0] d, input logic rnw);
        case (who)
            0:       begin bus.dl_req = v;  bus.dl_addr = a;  bus.dl_data = d; end
            1:       begin bus.cpu_req = v; bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_rnw = rnw; end
            default: begin bus.sr_req = v;  bus.sr_addr = a;  bus.sr_din = d;  bus.sr_rnw = rnw; end
        endcase
    endtask

    task automatic do_xfer(input int who, input logic [AW-1:0] a, input logic [7:0] d,
                           input logic rnw_in, input int l);
        int         n;
        logic       got;
        logic       rnw;
        logic [7:0] expd;
        rnw  = (who == 0) ? 1'b0 : rnw_in;
        expd = exp_rd(a);
        lat  = l;
        drive_req(who, 1'b1, a, d, rnw);
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            tick();
            n++;
            if (n == 1) begin
                chk("xfer_mem_ce", bus.mem_ce, 1);
                chk("xfer_mem_addr", bus.mem_addr, a);
                chk("xfer_mem_rnw", bus.mem_rnw, rnw);
            end
            got = ack_of(who);
        end
        chk("xfer_ack_seen", got, 1);
        chk("xfer_latency", n, l + 2);
        if (who == 1) chk("xfer_wait_n_at_ack", bus.cpu_wait_n, 1);
        if (rnw && who == 1) chk("xfer_cpu_rdata", bus.cpu_rdata, expd);
        if (rnw && who == 2) chk("xfer_sr_rdata", bus.sr_rdata, expd);
        if (!rnw) exp_mem[a] = d;
        drive_req(who, 1'b0, a, d, rnw);
        tick();
        chk("xfer_ack_one_cycle", ack_of(who), 0);
    endtask

    initial begin
        logic [AW-1:0] a, sa, ca;
        logic [7:0]    d, dd;
        int            n, cnt, since, bad, sr_g, n_sr, multi, nord, who;
        int            ord [3];
        int            at  [3];
        logic          got, done, prev_ce, exp_sr;

        drive_req(0, 1'b0, '0, 8'h00, 1'b0);
        drive_req(1, 1'b0, '0, 8'h00, 1'b1);
        drive_req(2, 1'b0, '0, 8'h00, 1'b1);

        tick();
        tick();
        chk("rst_mem_ce", bus.mem_ce, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_mem_rnw", bus.mem_rnw, 1);
        chk("rst_acks", {bus.dl_ack, bus.cpu_ack, bus.sr_ack}, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 8'hFF);
        chk("rst_sr_rdata", bus.sr_rdata, 8'hFF);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_wait_n", bus.cpu_wait_n, 1);
        reset = 1'b0;
        tick();

        // Directed CPU read with mem_done two cycles after mem_ce rises.
        phys_mem[27'h0001234] = 8'hA5;
        exp_mem[27'h0001234]  = 8'hA5;
        lat = 2;
        drive_req(1, 1'b1, 27'h0001234, 8'h00, 1'b1);
        #1;
        chk("rd_wait_n_N", bus.cpu_wait_n, 0);
        tick();
        chk("rd_ce_N1", bus.mem_ce, 1);
        chk("rd_addr_N1", bus.mem_addr, 27'h0001234);
        chk("rd_rnw_N1", bus.mem_rnw, 1);
        chk("rd_wait_n_N1", bus.cpu_wait_n, 0);
        tick();
        chk("rd_ce_N2", bus.mem_ce, 1);
        chk("rd_wait_n_N2", bus.cpu_wait_n, 0);
        tick();
        chk("rd_ce_N3", bus.mem_ce, 1);
        chk("rd_ack_N3", bus.cpu_ack, 0);
        chk("rd_wait_n_N3", bus.cpu_wait_n, 0);
        tick();
        chk("rd_ce_N4", bus.mem_ce, 0);
        chk("rd_ack_N4", bus.cpu_ack, 1);
        chk("rd_data_N4", bus.cpu_rdata, 8'hA5);
        chk("rd_wait_n_N4", bus.cpu_wait_n, 1);
        bus.cpu_req = 1'b0;
        tick();
        chk("rd_ack_N5", bus.cpu_ack, 0);
        chk("rd_data_held", bus.cpu_rdata, 8'hA5);

        // Three simultaneous requests: download writes what the CPU then reads back.
        a  = AW'($urandom);
        d  = 8'($urandom);
        sa = a ^ 27'h100;
        dd = 8'($urandom);
        lat = 0;
        drive_req(0, 1'b1, a, d, 1'b0);
        drive_req(1, 1'b1, a, 8'h00, 1'b1);
        drive_req(2, 1'b1, sa, dd, 1'b0);
        nord = 0; multi = 0; bad = 0;
        for (int k = 0; k < 3; k++) begin ord[k] = -1; at[k] = -1; end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (int'(bus.dl_ack) + int'(bus.cpu_ack) + int'(bus.sr_ack) > 1) multi++;
            if (bus.cpu_req && !bus.cpu_ack && bus.cpu_wait_n !== 1'b0) bad++;
            if (bus.dl_ack && nord < 3)  begin ord[nord] = 0; at[nord] = i; nord++; bus.dl_req = 1'b0; end
            if (bus.cpu_ack && nord < 3) begin ord[nord] = 1; at[nord] = i; nord++; bus.cpu_req = 1'b0; end
            if (bus.sr_ack && nord < 3)  begin ord[nord] = 2; at[nord] = i; nord++; bus.sr_req = 1'b0; end
        end
        chk("sim_num_acks", nord, 3);
        chk("sim_order", {ord[0][7:0], ord[1][7:0], ord[2][7:0]}, 32'h00_00_01_02);
        chk("sim_ack_cycles", {at[0][7:0], at[1][7:0], at[2][7:0]}, 32'h00_02_05_08);
        chk("sim_multi_ack", multi, 0);
        chk("sim_wait_n_low", bad, 0);
        chk("sim_cpu_rdata", bus.cpu_rdata, d);
        chk("sim_sr_written", rd_phys(sa), dd);
        exp_mem[a]  = d;
        exp_mem[sa] = dd;

        // A stray mem_done while idle must not start or complete anything.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        chk("stray_ce", bus.mem_ce, 0);
        chk("stray_acks", {bus.dl_ack, bus.cpu_ack, bus.sr_ack}, 0);
        tick();
        chk("stray_acks2", {bus.dl_ack, bus.cpu_ack, bus.sr_ack}, 0);

        // Random single transfers against the reference memory.
        for (int i = 0; i < 12; i++) begin
            who = int'($urandom_range(0, 2));
            a   = 27'h2000 + AW'($urandom_range(0, 3));
            d   = 8'($urandom);
            n   = int'($urandom_range(0, 3));
            do_xfer(who, a, d, 1'($urandom_range(0, 1)), n);
        end

        // Starvation: CPU back-to-back while SRAM waits.
        sa = 27'h0500;
        ca = 27'h0600;
        lat = 1;
        drive_req(1, 1'b1, ca, 8'h00, 1'b1);
        drive_req(2, 1'b1, sa, 8'h00, 1'b1);
        since = 0; prev_ce = 1'b0; bad = 0; sr_g = -1; n_sr = 0; done = 1'b0;
        for (int i = 1; i <= 200 && !done; i++) begin
            tick();
            if (bus.mem_ce && !prev_ce) begin
                exp_sr = ((i - 1) - since) >= 64;
                if ((bus.mem_addr == sa) != exp_sr) bad++;
                if (bus.mem_addr == sa) begin
                    n_sr++;
                    if (sr_g < 0) sr_g = i - 1;
                end
            end
            prev_ce = bus.mem_ce;
            if (bus.sr_ack) since = i + 1;
            if (i >= 90 && bus.cpu_ack) begin
                bus.cpu_req = 1'b0;
                bus.sr_req  = 1'b0;
                done = 1'b1;
            end
        end
        chk("starve_finished", done, 1);
        chk("starve_model", bad, 0);
        chk("starve_sr_grant_cycle", sr_g, 64);
        chk("starve_sr_grants", n_sr, 1);
        chk("starve_sr_rdata", bus.sr_rdata, exp_rd(sa));
        chk("starve_cpu_rdata", bus.cpu_rdata, exp_rd(ca));
        tick();
        tick();
        chk("starve_idle", bus.mem_ce, 0);

        // CPU write: requester inputs wander during ISSUE, the memory side must not.
        a = 27'h3000 + AW'($urandom_range(0, 255));
        d = dflt(a) ^ 8'hFF;
        lat = 3;
        drive_req(1, 1'b1, a, d, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("wr_ce_stable", bus.mem_ce, 1);
            chk("wr_addr_stable", bus.mem_addr, a);
            chk("wr_din_stable", bus.mem_din, d);
            chk("wr_rnw_stable", bus.mem_rnw, 0);
            bus.cpu_addr = AW'($urandom);
            bus.cpu_din  = 8'($urandom);
            tick();
        end
        chk("wr_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        chk("wr_mem_content", rd_phys(a), d);
        exp_mem[a] = d;
        tick();

        // Hung transfer: no mem_done ever.
        a = 27'h0004321;
        lat = 1000000;
        drive_req(1, 1'b1, a, 8'h00, 1'b1);
        n = 0; cnt = 0; got = 1'b0;
        while (!got && n < 300) begin
            tick();
            n++;
            if (bus.mem_ce) cnt++;
            got = bus.cpu_ack;
        end
        chk("tmo_ack_seen", got, 1);
        chk("tmo_ack_cycle", n, 256);
        chk("tmo_ce_cycles", cnt, 255);
        chk("tmo_ce_low", bus.mem_ce, 0);
        chk("tmo_rdata", bus.cpu_rdata, 8'hFF);
        chk("tmo_err", bus.timeout_err, 1);
        bus.cpu_req = 1'b0;
        tick();
        do_xfer(2, 27'h2001, 8'h00, 1'b1, 0);
        chk("tmo_err_sticky", bus.timeout_err, 1);

        // Reset in the middle of a transfer.
        lat = 1000000;
        drive_req(1, 1'b1, 27'h0007777, 8'h5C, 1'b0);
        tick();
        tick();
        tick();
        chk("mid_ce_before", bus.mem_ce, 1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        chk("mid_ce", bus.mem_ce, 0);
        chk("mid_addr", bus.mem_addr, 0);
        chk("mid_din", bus.mem_din, 0);
        chk("mid_rnw", bus.mem_rnw, 1);
        chk("mid_acks", {bus.dl_ack, bus.cpu_ack, bus.sr_ack}, 0);
        chk("mid_cpu_rdata", bus.cpu_rdata, 8'hFF);
        chk("mid_sr_rdata", bus.sr_rdata, 8'hFF);
        chk("mid_timeout_err", bus.timeout_err, 0);
        chk("mid_wait_n", bus.cpu_wait_n, 1);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.cpu_ack !== 1'b0 || bus.mem_ce !== 1'b0) bad++;
        end
        chk("mid_no_ack", bad, 0);
        do_xfer(1, 27'h2002, 8'h00, 1'b1, 1);
        chk("mid_timeout_err_after", bus.timeout_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
